change_dispenser: RTL and testbench



---
 rtl/vending_pkg.sv | 37 +++
 rtl/coin_selector.sv | 29 ++
 rtl/change_dispenser.sv | 131 +++++++++++++
 tb/tb_change_dispenser.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending machine change path.
// Optional feature macro used downstream: VENDING_CHANGE_QUARTER_EN.
package vending_pkg;

    localparam int unsigned REM_W     = 3;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned COIN_W    = 2;

    // Coin values in nickel units
    localparam int unsigned NICKEL_U  = 1;
    localparam int unsigned DIME_U    = 2;
    localparam int unsigned QUARTER_U = 5;

    typedef enum logic [COIN_W-1:0] {
        NONE    = 2'b00,
        NICKEL  = 2'b01,
        DIME    = 2'b10,
        QUARTER = 2'b11
    } coin_e;

    typedef enum logic [2:0] {
        IDLE,
        VEND,
        SELECT,
        REQ,
        WAIT_LOW,
        GAP,
        FAULT
    } disp_state_e;

    // Result of one greedy coin pick
    typedef struct packed {
        coin_e             coin;
        logic [REM_W-1:0]  rem_next;
    } coin_sel_t;

endpackage

// File: rtl/coin_selector.sv
// Greedy coin pick: maps the remaining change to the next coin and the
// change left afterwards. Quarters only when VENDING_CHANGE_QUARTER_EN is defined.
module coin_selector
    import vending_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    output coin_sel_t        sel_c
);

    // Largest coin that fits; rem=0 yields NONE with rem unchanged
    always_comb begin
        sel_c.coin     = NONE;
        sel_c.rem_next = rem;
`ifdef VENDING_CHANGE_QUARTER_EN
        if (rem >= REM_W'(QUARTER_U)) begin
            sel_c.coin     = QUARTER;
            sel_c.rem_next = rem - REM_W'(QUARTER_U);
        end else
`endif
        if (rem >= REM_W'(DIME_U)) begin
            sel_c.coin     = DIME;
            sel_c.rem_next = rem - REM_W'(DIME_U);
        end else if (rem >= REM_W'(NICKEL_U)) begin
            sel_c.coin     = NICKEL;
            sel_c.rem_next = rem - REM_W'(NICKEL_U);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: releases the soda, then pays change to the coin hopper
// one coin at a time over req/ack. Quarter support via VENDING_CHANGE_QUARTER_EN
// (confined to coin_selector).
module change_dispenser
    import vending_pkg::*;
#(
    parameter int unsigned VEND_CYCLES    = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              soda_i,
    input  logic [REM_W-1:0]  change_i,
    input  logic              ack_i,
    output logic              vend_o,
    output logic              req_o,
    output logic [COIN_W-1:0] coin_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic              fault_o
);

    // Shared down-counter loads: counting ends on the cycle it reads zero
    localparam logic [CNT_W-1:0] VEND_LOAD = CNT_W'(VEND_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);

    disp_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic                vend_d, req_d, busy_d, overrun_d, fault_d;
    logic [COIN_W-1:0]   coin_d;
    coin_sel_t           sel_c;

    coin_selector u_coin_selector (
        .rem   (rem_q),
        .sel_c (sel_c)
    );

    // State, counter, remaining change and registered outputs
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            vend_o    <= 1'b0;
            req_o     <= 1'b0;
            coin_o    <= '0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
            fault_o   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            vend_o    <= vend_d;
            req_o     <= req_d;
            coin_o    <= coin_d;
            busy_o    <= busy_d;
            overrun_o <= overrun_d;
            fault_o   <= fault_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they
    // line up with the state register
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;

        unique case (state_q)
            IDLE: begin
                if (soda_i) begin
                    rem_d   = change_i;
                    cnt_d   = VEND_LOAD;
                    state_d = VEND;
                end
            end
            VEND: begin
                if (cnt_q == '0) state_d = SELECT;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            SELECT: begin
                if (rem_q == '0) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = sel_c.rem_next;
                    cnt_d   = TO_LOAD;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_i)             state_d = WAIT_LOW;
                else if (cnt_q == '0)  state_d = FAULT;
                else                   cnt_d   = cnt_q - CNT_W'(1);
            end
            WAIT_LOW: begin
                // A held ack must drop before the next coin is requested
                if (!ack_i) begin
                    cnt_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = SELECT;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        vend_d    = (state_d == VEND);
        req_d     = (state_d == REQ);
        busy_d    = (state_d != IDLE);
        fault_d   = fault_o | (state_d == FAULT);
        overrun_d = overrun_o | (soda_i && (state_q != IDLE));

        // Coin is picked on entry to REQ and held until the request ends
        coin_d = COIN_W'(NONE);
        if (state_d == REQ) begin
            coin_d = (state_q == SELECT) ? COIN_W'(sel_c.coin) : coin_o;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser; expected values are hand-computed.
// Honours VENDING_CHANGE_QUARTER_EN for the rem=7 coin sequence.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset_ni;
    logic       soda;
    logic [2:0] change;
    logic       ack;
    logic       vend_o;
    logic       req_o;
    logic [1:0] coin_o;
    logic       busy_o;
    logic       overrun_o;
    logic       fault_o;

    int errors = 0;
    int checks = 0;

    // Per-transaction observations
    int coins[$];
    int vend_steps, vend_first, req_first, busy_steps;
    int min_gap, coin_ok, timed_out, fault_k;

    change_dispenser dut (
        .clk_i     (clk),
        .reset_ni  (reset_ni),
        .soda_i    (soda),
        .change_i  (change),
        .ack_i     (ack),
        .vend_o    (vend_o),
        .req_o     (req_o),
        .coin_o    (coin_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o),
        .fault_o   (fault_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int coin_at(input int i);
        return (i < coins.size()) ? coins[i] : -1;
    endfunction

    // Step to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        soda     = 1'b0;
        ack      = 1'b0;
        change   = 3'd0;
        reset_ni = 1'b0;
        repeat (2) tick();
        reset_ni = 1'b1;
        tick();
    endtask

    // Pulse soda with chg, then watch the transaction step by step.
    // Step k is the observation just after the k-th edge following capture.
    // The hopper acks once req has been seen for ack_dly steps (0 = never),
    // holding ack for ack_len steps. A stray soda is pulsed at step ovr_k.
    task automatic run_txn(input logic [2:0] chg, input int ack_dly,
                           input int ack_len, input int ovr_k, input int max_k);
        int         k, req_age, ack_left, gap;
        logic       prev_req;
        logic [1:0] prev_coin;
        coins.delete();
        vend_steps = 0; vend_first = -1; req_first = -1; busy_steps = 0;
        min_gap = 1000; coin_ok = 1; timed_out = 0; fault_k = -1;
        req_age = 0; ack_left = 0; gap = -1; prev_req = 1'b0; prev_coin = 2'b00;
        change = chg;
        soda   = 1'b1;
        tick();
        soda   = 1'b0;
        change = 3'd0;
        k = 0;
        forever begin
            if (vend_o) begin
                vend_steps++;
                if (vend_first < 0) vend_first = k;
            end
            if (busy_o) busy_steps++;
            if (req_o && !prev_req) begin
                coins.push_back(int'(coin_o));
                if (req_first < 0) req_first = k;
                if (gap > 0 && gap < min_gap) min_gap = gap;
                req_age = 0;
            end
            if (req_o && prev_req && coin_o != prev_coin) coin_ok = 0;
            if (!req_o && coin_o != 2'b00) coin_ok = 0;
            if (!req_o && prev_req)  gap = 1;
            else if (!req_o && gap > 0) gap++;
            if (fault_o) begin
                fault_k = k;
                break;
            end
            if (!busy_o) break;
            if (k >= max_k) begin
                timed_out = 1;
                break;
            end
            if (req_o) req_age++;
            if (req_o && ack_dly > 0 && req_age == ack_dly) ack_left = ack_len;
            ack = (ack_left > 0);
            if (ack_left > 0) ack_left--;
            soda   = (k == ovr_k);
            change = (k == ovr_k) ? 3'd5 : 3'd0;
            prev_req  = req_o;
            prev_coin = coin_o;
            k++;
            tick();
        end
        soda   = 1'b0;
        ack    = 1'b0;
        change = 3'd0;
    endtask

    initial begin
        int exp7[$];
        int n;

        reset_ni = 1'b0;
        soda     = 1'b0;
        ack      = 1'b0;
        change   = 3'd0;

        // Reset state
        do_reset();
        check_eq("rst_vend",    int'(vend_o),    0);
        check_eq("rst_req",     int'(req_o),     0);
        check_eq("rst_coin",    int'(coin_o),    0);
        check_eq("rst_busy",    int'(busy_o),    0);
        check_eq("rst_overrun", int'(overrun_o), 0);
        check_eq("rst_fault",   int'(fault_o),   0);

        // change=3, ack two cycles into each request: dime then nickel
        run_txn(3'd3, 2, 1, -1, 100);
        check_eq("c3_timeout",    timed_out,      0);
        check_eq("c3_vend_first", vend_first,     0);
        check_eq("c3_vend_len",   vend_steps,     4);
        check_eq("c3_req_first",  req_first,      5);
        check_eq("c3_ncoins",     coins.size(),   2);
        check_eq("c3_coin0",      coin_at(0),     2);
        check_eq("c3_coin1",      coin_at(1),     1);
        check_eq("c3_gap",        min_gap,        4);
        check_eq("c3_busy_len",   busy_steps,     17);
        check_eq("c3_stable",     coin_ok,        1);
        check_eq("c3_overrun",    int'(overrun_o), 0);
        check_eq("c3_fault",      int'(fault_o),   0);

        // change=0: vend only, back to idle quickly
        run_txn(3'd0, 2, 1, -1, 100);
        check_eq("c0_timeout",    timed_out,    0);
        check_eq("c0_vend_len",   vend_steps,   4);
        check_eq("c0_ncoins",     coins.size(), 0);
        check_eq("c0_busy_len",   busy_steps,   5);

        // change=7, ack on first request cycle
`ifdef VENDING_CHANGE_QUARTER_EN
        exp7 = '{3, 2};
`else
        exp7 = '{2, 2, 2, 1};
`endif
        run_txn(3'd7, 1, 1, -1, 200);
        check_eq("c7_timeout", timed_out,    0);
        check_eq("c7_ncoins",  coins.size(), exp7.size());
        n = exp7.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("c7_coin%0d", i), coin_at(i), exp7[i]);
        end
        check_eq("c7_stable",  coin_ok,      1);

        // Stray soda during REQ and a 5-cycle level ack
        run_txn(3'd3, 2, 5, 6, 100);
        check_eq("ov_timeout",  timed_out,       0);
        check_eq("ov_overrun",  int'(overrun_o), 1);
        check_eq("ov_ncoins",   coins.size(),    2);
        check_eq("ov_coin0",    coin_at(0),      2);
        check_eq("ov_coin1",    coin_at(1),      1);
        check_eq("ov_gap",      min_gap,         8);
        check_eq("ov_busy_len", busy_steps,      25);

        // Soda arriving on the cycle the FSM returns to IDLE is an overrun
        do_reset();
        run_txn(3'd0, 2, 1, 4, 100);
        check_eq("ir_busy_len", busy_steps,      5);
        check_eq("ir_overrun",  int'(overrun_o), 1);
        repeat (3) tick();
        check_eq("ir_no_vend",  int'(vend_o),    0);
        check_eq("ir_idle",     int'(busy_o),    0);

        // Hopper never acks: fault exactly TIMEOUT_CYCLES after req rose
        do_reset();
        run_txn(3'd3, 0, 0, -1, 400);
        check_eq("to_timeout",   timed_out,            0);
        check_eq("to_req_first", req_first,            5);
        check_eq("to_latency",   fault_k - req_first,  255);
        check_eq("to_req_low",   int'(req_o),          0);
        check_eq("to_fault",     int'(fault_o),        1);
        check_eq("to_vend_low",  int'(vend_o),         0);
        repeat (20) tick();
        check_eq("to_fault_sticky", int'(fault_o),     1);
        check_eq("to_req_stays",    int'(req_o),       0);
        check_eq("to_ovr_before",   int'(overrun_o),   0);
        soda = 1'b1;
        tick();
        soda = 1'b0;
        tick();
        check_eq("to_overrun",   int'(overrun_o),      1);
        check_eq("to_no_vend",   int'(vend_o),         0);
        reset_ni = 1'b0;
        #2;
        check_eq("to_fault_clr", int'(fault_o),        0);
        check_eq("to_ovr_clr",   int'(overrun_o),      0);
        tick();
        reset_ni = 1'b1;
        tick();

        // Asynchronous reset in the middle of a request
        do_reset();
        change = 3'd3;
        soda   = 1'b1;
        tick();
        soda   = 1'b0;
        change = 3'd0;
        n = 0;
        while (!req_o && n < 20) begin
            tick();
            n++;
        end
        check_eq("ar_in_req", int'(req_o), 1);
        #2;
        reset_ni = 1'b0;
        #1;
        check_eq("ar_req",  int'(req_o),  0);
        check_eq("ar_vend", int'(vend_o), 0);
        check_eq("ar_busy", int'(busy_o), 0);
        check_eq("ar_coin", int'(coin_o), 0);
        tick();
        reset_ni = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
